valid_stream_receiver: RTL and testbench

- Receiving end of the valid-qualified data interface driven by producer-type blocks (data_out plus valid_out, no backpressure).
- Captures every valid beat into a small first-word-fall-through buffer.
- Re-emits the beats to a downstream that supports ready/valid backpressure.
- Counts accepted and dropped beats, and flags overflow for software and debug.

---
 rtl/valid_stream_pkg.sv | 35 +++
 rtl/valid_stream_fifo.sv | 95 +++++++++
 rtl/valid_stream_receiver.sv | 99 +++++++++
 tb/tb_valid_stream_receiver.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/valid_stream_pkg.sv
// ----------------------------------------------------------------------------
// valid_stream_pkg
// Shared definitions for the valid-stream receiver slice:
//   - default data width, buffer depth and counter width
//   - level_width(): number of bits needed to hold an occupancy of 0..depth
//   - occ_t / occ_of(): coarse occupancy classification (EMPTY/PARTIAL/FULL)
//     used by assertions and coverage, never by the datapath itself
// ----------------------------------------------------------------------------
package valid_stream_pkg;

  localparam int VSR_DATA_W = 8;
  localparam int VSR_DEPTH  = 4;
  localparam int VSR_CNT_W  = 16;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_t;

  // One extra bit beyond the pointer width so that the value DEPTH fits.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic occ_t occ_of(input int lvl, input int depth);
    if (lvl == 0) begin
      return EMPTY;
    end else if (lvl >= depth) begin
      return FULL;
    end
    return PARTIAL;
  endfunction

endpackage

// File: rtl/valid_stream_fifo.sv
// ----------------------------------------------------------------------------
// valid_stream_fifo
// First-word-fall-through storage for the receiver. The caller decides
// whether a push is legal; this block simply writes, reads and tracks level.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   push         write wdata at the tail this cycle (caller guarantees room)
//   pop          retire the head entry this cycle (caller guarantees data)
//   wdata        data to write
//   rdata        registered head-of-buffer data; holds last value when empty
//   level        occupancy 0..DEPTH
//   full         level == DEPTH
// ----------------------------------------------------------------------------
module valid_stream_fifo
  import valid_stream_pkg::*;
#(
  parameter int DATA_W = VSR_DATA_W,
  parameter int DEPTH  = VSR_DEPTH,
  localparam int LVL_W = level_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [LVL_W-1:0]  level,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_nxt;
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] head_nxt;

  // Next read pointer and occupancy. A simultaneous push and pop leaves the
  // level unchanged while both pointers still advance.
  always_comb begin
    rd_ptr_nxt = pop ? rd_ptr + 1'b1 : rd_ptr;
    level_nxt  = level_q;
    case ({push, pop})
      2'b10:   level_nxt = level_q + 1'b1;
      2'b01:   level_nxt = level_q - 1'b1;
      default: level_nxt = level_q;
    endcase
  end

  // The head is kept in its own register so the output is purely registered
  // and keeps its last value once the buffer drains. When the entry that will
  // be at the head is being written this very cycle (buffer empty after any
  // pop), it is taken from wdata, since mem is not yet updated.
  always_comb begin
    head_nxt = head_q;
    if (level_nxt != '0) begin
      if (push && (wr_ptr == rd_ptr_nxt)) begin
        head_nxt = wdata;
      end else begin
        head_nxt = mem[rd_ptr_nxt];
      end
    end
  end

  // Storage, pointers, level and head register. Pointers wrap naturally at
  // DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      head_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr  <= rd_ptr_nxt;
      level_q <= level_nxt;
      head_q  <= head_nxt;
    end
  end

  assign rdata = head_q;
  assign level = level_q;
  assign full  = (level_q == LVL_W'(DEPTH));

endmodule

// File: rtl/valid_stream_receiver.sv
// ----------------------------------------------------------------------------
// valid_stream_receiver
// Accepts a valid-qualified stream that cannot be stalled, buffers it, and
// re-emits it on a ready/valid interface. Beats arriving while the buffer is
// full and nothing leaves are dropped and counted.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   data_in       upstream data, sampled when valid_in=1
//   valid_in      upstream beat qualifier
//   out_data      head-of-buffer data
//   out_valid     buffer not empty
//   out_ready     downstream accepts the head this cycle
//   level         occupancy 0..DEPTH
//   full          level == DEPTH
//   overflow      sticky drop flag, cleared by overflow_clr (a new drop wins)
//   overflow_clr  single-cycle clear of overflow
//   rx_count      accepted beats, wrapping
//   drop_count    dropped beats, saturating, cleared only by reset
// ----------------------------------------------------------------------------
module valid_stream_receiver
  import valid_stream_pkg::*;
#(
  parameter int DATA_W = VSR_DATA_W,
  parameter int DEPTH  = VSR_DEPTH,
  parameter int CNT_W  = VSR_CNT_W,
  localparam int LVL_W = level_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              overflow,
  input  logic              overflow_clr,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  drop_count
);

  logic pop;
  logic push_ok;
  logic drop;
  occ_t occ;

  // A full buffer can still take a beat when the head leaves in the same
  // cycle; otherwise a beat arriving at a full buffer is lost.
  assign pop     = out_valid & out_ready;
  assign push_ok = valid_in & (~full | pop);
  assign drop    = valid_in & full & ~pop;

  valid_stream_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .pop   (pop),
    .wdata (data_in),
    .rdata (out_data),
    .level (level),
    .full  (full)
  );

  assign out_valid = (level != '0);

  // Sticky overflow flag and the two beat counters. Setting overflow takes
  // priority over clearing it so that a drop is never silently lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      rx_count   <= '0;
      drop_count <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
      if (push_ok) begin
        rx_count <= rx_count + 1'b1;
      end
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  // Occupancy class, used only to cross-check the status outputs.
  assign occ = occ_of(int'(level), DEPTH);

  assert property (@(posedge clk) disable iff (!rst_n) (occ == FULL) == full);
  assert property (@(posedge clk) disable iff (!rst_n) (occ == EMPTY) == !out_valid);
  assert property (@(posedge clk) disable iff (!rst_n) int'(level) <= DEPTH);

endmodule

// File: tb/tb_valid_stream_receiver.sv
// ----------------------------------------------------------------------------
// tb_valid_stream_receiver
// Directed scenarios followed by randomized traffic, all checked against a
// queue-based reference model of the receiver's accept/drop rules.
// ----------------------------------------------------------------------------
module tb_valid_stream_receiver;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 16;
  localparam int LVL_W  = $clog2(DEPTH) + 1;

  logic              clk;
  logic              rst_n;
  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [LVL_W-1:0]  level;
  logic              full;
  logic              overflow;
  logic              overflow_clr;
  logic [CNT_W-1:0]  rx_count;
  logic [CNT_W-1:0]  drop_count;

  int vectors;
  int miscompares;

  logic [DATA_W-1:0] mq[$];
  logic [CNT_W-1:0]  m_rx;
  logic [CNT_W-1:0]  m_drop;
  logic              m_ovf;

  valid_stream_receiver #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .full         (full),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .rx_count     (rx_count),
    .drop_count   (drop_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the buffer.
  task automatic checkAll();
    checkOutput("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    checkOutput("level", 32'(level), 32'(mq.size()));
    checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
    checkOutput("overflow", 32'(overflow), 32'(m_ovf));
    checkOutput("rx_count", 32'(rx_count), 32'(m_rx));
    checkOutput("drop_count", 32'(drop_count), 32'(m_drop));
    if (mq.size() != 0) begin
      checkOutput("out_data", 32'(out_data), 32'(mq[0]));
    end
  endtask

  // Reference model: one clock edge of the receiver's behaviour.
  task automatic modelStep(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic c);
    bit do_pop;
    bit do_push;
    do_pop  = (mq.size() != 0) && r;
    do_push = v && ((mq.size() < DEPTH) || do_pop);
    if (do_pop) begin
      void'(mq.pop_front());
    end
    if (do_push) begin
      mq.push_back(d);
      m_rx = m_rx + 1'b1;
    end
    if (v && !do_push) begin
      m_ovf = 1'b1;
      if (m_drop != '1) begin
        m_drop = m_drop + 1'b1;
      end
    end else if (c) begin
      m_ovf = 1'b0;
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_rx   = '0;
    m_drop = '0;
    m_ovf  = 1'b0;
  endtask

  // Drive one cycle of inputs, check outputs ahead of the edge, then advance
  // the model past the edge. Entered and left at 1 time unit after a rising edge.
  task automatic applyStimulus(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic c);
    valid_in     = v;
    data_in      = d;
    out_ready    = r;
    overflow_clr = c;
    checkAll();
    @(posedge clk);
    #1;
    modelStep(v, d, r, c);
  endtask

  initial begin
    logic [CNT_W-1:0] rx_start;
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    valid_in     = 1'b0;
    data_in      = '0;
    out_ready    = 1'b0;
    overflow_clr = 1'b0;
    modelReset();

    #12;
    $display("[TB] reset values");
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_level", 32'(level), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_rx_count", 32'(rx_count), 32'd0);
    checkOutput("rst_drop_count", 32'(drop_count), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single beat");
    applyStimulus(1'b1, 8'hA5, 1'b1, 1'b0);
    checkOutput("single_valid", 32'(out_valid), 32'd1);
    checkOutput("single_data", 32'(out_data), 32'hA5);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("single_drained", 32'(out_valid), 32'd0);
    checkOutput("single_rx", 32'(rx_count), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] fill");
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
    checkOutput("fill_level", 32'(level), 32'd4);
    checkOutput("fill_full", 32'(full), 32'd1);

    $display("[TB] overflow");
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_drops", 32'(drop_count), 32'd2);
    checkOutput("ovf_rx", 32'(rx_count), 32'd5);
    checkOutput("ovf_head", 32'(out_data), 32'h11);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("clr_flag", 32'(overflow), 32'd0);
    checkOutput("clr_drops", 32'(drop_count), 32'd2);

    $display("[TB] full with simultaneous push and pop");
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0);
    checkOutput("pp_level", 32'(level), 32'd4);
    checkOutput("pp_drops", 32'(drop_count), 32'd2);
    checkOutput("pp_head", 32'(out_data), 32'h22);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end
    checkOutput("pp_empty", 32'(level), 32'd0);

    $display("[TB] clear/set collision");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'h99, 1'b0, 1'b1);
    checkOutput("coll_flag", 32'(overflow), 32'd1);
    checkOutput("coll_drops", 32'(drop_count), 32'd3);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic r;
      if (i < 200) begin
        r = ($urandom_range(0, 3) == 0);
      end else begin
        r = ($urandom_range(0, 3) != 0);
      end
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), r, 1'($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
    end

    $display("[TB] continuous stream");
    rx_start = m_rx;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("stream_rx", 32'(rx_count - rx_start), 32'd300);
    checkOutput("stream_empty", 32'(level), 32'd0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 8'(8'hE0 + i), 1'($urandom_range(0, 1)), 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("arst_level", 32'(level), 32'd0);
    checkOutput("arst_rx", 32'(rx_count), 32'd0);
    checkOutput("arst_overflow", 32'(overflow), 32'd0);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    modelReset();
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b1, 1'b0);
    checkOutput("post_rst_valid", 32'(out_valid), 32'd1);
    checkOutput("post_rst_data", 32'(out_data), 32'hC3);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
